alu_serial_seq: RTL and testbench
=================================

Name: alu_serial_seq

Overview:
- Sequencer that drives the team's 1-bit ALU slice (3-bit oper, a, b, c_in in; sum, c_out out) bit-serially to perform a WIDTH-bit operation.
- Latches a request, then presents operand bits LSB-first, one per clock, and feeds each c_out back as the next c_in.
- Assembles sum bits into a parallel result, then pulses done.
- Sits between a parallel requester (control FSM or bench) and the combinational ALU slice instance.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- OPER_W, 3, ALU operation code width; the code is opaque to this block and passed through.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request strobe; sampled only in IDLE
- oper  input  OPER_W  operation code, captured at accept
- a  input  WIDTH  operand A, captured at accept
- b  input  WIDTH  operand B, captured at accept
- c_in  input  1  initial carry, captured at accept
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  assembled sum bits, held until next accept
- c_out  output  1  final carry of last bit, held until next accept
- alu_oper  output  OPER_W  to slice oper
- alu_a  output  1  to slice a
- alu_b  output  1  to slice b
- alu_c_in  output  1  to slice c_in
- alu_sum  input  1  from slice sum
- alu_c_out  input  1  from slice c_out

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; shift registers, bit counter, carry register, result, c_out, alu_oper = 0.
  - busy=0, done=0.
  - An in-flight operation is abandoned with no done pulse.
- FSM states: IDLE, SHIFT, DONE; all outputs are registered or decoded from state.
- IDLE:
  - alu_a=alu_b=alu_c_in=0.
  - On the edge with start=1: capture a, b, c_in, oper; cnt=0; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT:
  - alu_a=a_sr[0], alu_b=b_sr[0], alu_oper=oper_reg.
  - alu_c_in = cin_reg when cnt==0, else carry_reg.
  - Each edge:
    - result shifts right with alu_sum into the MSB.
    - carry_reg <= alu_c_out.
    - a_sr and b_sr shift right, zero-filled.
    - cnt++.
  - When cnt==WIDTH-1, that edge moves to DONE.
  - After WIDTH edges, bit i of result = slice sum for operand bit i.
- DONE:
  - done=1 for exactly one cycle; c_out=carry_reg; next edge goes to IDLE.
- Latency: accept edge at cycle 0; done high during cycle WIDTH+1 (WIDTH SHIFT cycles + 1).
- Back-to-back: start during SHIFT/DONE is ignored, not queued. The earliest next accept is the first IDLE cycle, so throughput is one op per WIDTH+2 cycles.
- result/c_out stay stable from DONE until the next accept edge. They are overwritten bit by bit during SHIFT; requesters must sample on done.
- Operand changes after accept have no effect.
- cnt width is clog2(WIDTH); no wrap beyond WIDTH-1 is reachable.

Optional Feature:
- ALU_SEQ_ZERO_FLAG_EN defined:
  - adds output port zero (1 bit), registered.
  - Set in the DONE transition to (final result == 0), held with result, reset to 0.
- Undefined: no zero port, no logic.

Decomposition:
- Shared package alu_pkg:
  - OPER_W constant.
  - State encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - Named oper codes used by the benches.
- One natural sub-module: alu_bit_sr.
  - Parameterised WIDTH load/shift-right register with serial-in and LSB serial-out.
  - Instantiated for a, b and result.

Test Plan:
- Bench uses a behavioural slice with oper 3'b000 = full add. WIDTH=8.
- Add, no carry: a=8'h5A, b=8'h3C, c_in=0, start at cycle 0 → done at cycle 9, result=8'h96, c_out=0, busy high cycles 1–9.
- Carry propagation: a=8'hFF, b=8'h01, c_in=0 → result=8'h00, c_out=1; zero=1 when ALU_SEQ_ZERO_FLAG_EN is defined.
- Initial carry used only on bit 0: a=8'h00, b=8'h00, c_in=1 → result=8'h01, c_out=0; alu_c_in=1 only in the first SHIFT cycle.
- start pulsed at cycles 3 and 9 during an op → ignored. Single done pulse; result unchanged by the second request's operands.
- rst asserted mid-SHIFT after 4 bits → immediately busy=0, result=0, state IDLE, no done. A following start with a=8'h01, b=8'h01 yields 8'h02.
- Back-to-back: start held high continuously → accepts every 10 cycles. done pulses at cycles 9, 19, …; each result matches its captured operands.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the bit-serial ALU sequencer: operation code width,
// FSM state encoding and the named operation codes used by requesters.
package alu_pkg;

  localparam int OPER_W = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [OPER_W-1:0] OPER_ADD = 3'b000;
  localparam logic [OPER_W-1:0] OPER_AND = 3'b001;
  localparam logic [OPER_W-1:0] OPER_OR  = 3'b010;
  localparam logic [OPER_W-1:0] OPER_XOR = 3'b011;

endpackage

// File: rtl/alu_bit_sr.sv
// Parallel-load, shift-right register with serial input at the MSB and the
// LSB presented as serial output. Load has priority over shift.
module alu_bit_sr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_q,
  output logic             o_sout
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_data;
    end else if (i_shift) begin
      r_q <= {i_sin, r_q[WIDTH-1:1]};
    end
  end

  assign o_q    = r_q;
  assign o_sout = r_q[0];

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer around a 1-bit ALU slice: LSB-first operand feed,
// carry fed back, sum bits assembled into a parallel result.
// Optional macro ALU_SEQ_ZERO_FLAG_EN adds a registered 'zero' output.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int OPER_W = alu_pkg::OPER_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OPER_W-1:0] oper,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              c_in,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              c_out,
  output logic [OPER_W-1:0] alu_oper,
  output logic              alu_a,
  output logic              alu_b,
  output logic              alu_c_in,
  output logic [1:0]        dbg_state,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic              zero,
`endif
  input  logic              alu_sum,
  input  logic              alu_c_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Handshake: start is only looked at in IDLE; a request seen there is
  // accepted on that edge, anything presented while busy is dropped.
  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [OPER_W-1:0] r_oper;
  logic              r_cin;
  logic              r_carry;
  logic              r_c_out;

  logic              w_accept;
  logic              w_shift;
  logic              w_last;
  logic [WIDTH-1:0]  w_a_q;
  logic [WIDTH-1:0]  w_b_q;
  logic [WIDTH-1:0]  w_res_q;
  logic              w_a_sout;
  logic              w_b_sout;
  logic              w_res_sout;
  logic              w_unused_taps;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_shift  = (r_state == ST_SHIFT);
  assign w_last   = w_shift && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_oper  <= '0;
      r_cin   <= 1'b0;
      r_carry <= 1'b0;
      r_c_out <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
            r_oper  <= oper;
            r_cin   <= c_in;
          end
        end
        ST_SHIFT: begin
          r_carry <= alu_c_out;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= ST_DONE;
            r_c_out <= alu_c_out;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  alu_bit_sr #(.WIDTH(WIDTH)) u_a_sr (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_load_data (a),
    .i_shift     (w_shift),
    .i_sin       (1'b0),
    .o_q         (w_a_q),
    .o_sout      (w_a_sout)
  );

  alu_bit_sr #(.WIDTH(WIDTH)) u_b_sr (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_load_data (b),
    .i_shift     (w_shift),
    .i_sin       (1'b0),
    .o_q         (w_b_q),
    .o_sout      (w_b_sout)
  );

  // Result is never loaded; after WIDTH shifts every stale bit has been
  // pushed out, so it only changes while SHIFT is running.
  alu_bit_sr #(.WIDTH(WIDTH)) u_res_sr (
    .clk         (clk),
    .rst         (rst),
    .i_load      (1'b0),
    .i_load_data ({WIDTH{1'b0}}),
    .i_shift     (w_shift),
    .i_sin       (alu_sum),
    .o_q         (w_res_q),
    .o_sout      (w_res_sout)
  );

  assign w_unused_taps = ^{w_a_q, w_b_q, w_res_sout};

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic             r_zero;
  logic [WIDTH-1:0] w_result_next;

  assign w_result_next = {alu_sum, w_res_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero <= 1'b0;
    end else if (w_last) begin
      r_zero <= (w_result_next == '0);
    end
  end

  assign zero = r_zero;
`endif

  // Initial carry applies to bit 0 only; later bits take the fed-back carry.
  assign alu_a     = w_shift & w_a_sout;
  assign alu_b     = w_shift & w_b_sout;
  assign alu_c_in  = w_shift & ((r_cnt == '0) ? r_cin : r_carry);
  assign alu_oper  = r_oper;

  assign busy      = (r_state == ST_SHIFT) || (r_state == ST_DONE);
  assign done      = (r_state == ST_DONE);
  assign result    = w_res_q;
  assign c_out     = r_c_out;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq with a behavioural 1-bit ALU slice.
// Optional macro ALU_SEQ_ZERO_FLAG_EN enables zero-flag checks.
module tb_alu_serial_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [OPER_W-1:0] oper;
  logic [W-1:0]      a;
  logic [W-1:0]      b;
  logic              c_in;
  logic              busy;
  logic              done;
  logic [W-1:0]      result;
  logic              c_out;
  logic [OPER_W-1:0] alu_oper;
  logic              alu_a;
  logic              alu_b;
  logic              alu_c_in;
  logic [1:0]        dbg_state;
  logic              alu_sum;
  logic              alu_c_out;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic              zero;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural slice; 3'b000 is a full adder.
  always_comb begin
    alu_sum   = 1'b0;
    alu_c_out = 1'b0;
    case (alu_oper)
      OPER_ADD: begin
        alu_sum   = alu_a ^ alu_b ^ alu_c_in;
        alu_c_out = (alu_a & alu_b) | (alu_c_in & (alu_a ^ alu_b));
      end
      OPER_AND: alu_sum = alu_a & alu_b;
      OPER_OR:  alu_sum = alu_a | alu_b;
      OPER_XOR: alu_sum = alu_a ^ alu_b;
      default:  ;
    endcase
  end

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .oper      (oper),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .c_out     (c_out),
    .alu_oper  (alu_oper),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c_in  (alu_c_in),
    .dbg_state (dbg_state),
`ifdef ALU_SEQ_ZERO_FLAG_EN
    .zero      (zero),
`endif
    .alu_sum   (alu_sum),
    .alu_c_out (alu_c_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a request for one edge; returns in the first SHIFT cycle.
  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    a     = va;
    b     = vb;
    c_in  = vc;
    oper  = OPER_ADD;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Waits (bounded) for done; lat counts cycles since the accept edge.
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check("done_seen", done, 1'b1);
  endtask

  logic [W-1:0] vec_a   [4];
  logic [W-1:0] vec_b   [4];
  logic [W-1:0] vec_res [3];
  logic         vec_co  [3];

  initial begin
    int lat;
    int n_done;
    int n_cin;
    logic [W-1:0] a_cap;

    rst   = 1'b1;
    start = 1'b0;
    oper  = '0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;
    step();
    step();

    // Reset state
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_c_out", c_out, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_alu_oper", alu_oper, 3'b000);
    check("rst_alu_a", alu_a, 1'b0);
    rst = 1'b0;
    step();
    check("idle_no_start", busy, 1'b0);

    // 5A + 3C = 96, exact latency and busy window, operand bits LSB-first
    a_cap = 8'h5A;
    launch(8'h5A, 8'h3C, 1'b0);
    a = 8'h00;
    b = 8'hFF;
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) step();
      check("add_busy", busy, 1'b1);
      check("add_done", done, (k == 9));
      if (k <= 8) begin
        check("add_alu_a", alu_a, a_cap[k-1]);
        check("add_alu_oper", alu_oper, OPER_ADD);
      end
    end
    check("add_result", result, 8'h96);
    check("add_c_out", c_out, 1'b0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check("add_zero", zero, 1'b0);
`endif
    step();
    check("add_idle_busy", busy, 1'b0);
    check("add_idle_done", done, 1'b0);
    check("add_hold_result", result, 8'h96);

    // FF + 01: full carry ripple
    launch(8'hFF, 8'h01, 1'b0);
    wait_done(lat);
    check("ripple_latency", lat, 9);
    check("ripple_result", result, 8'h00);
    check("ripple_c_out", c_out, 1'b1);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check("ripple_zero", zero, 1'b1);
`endif
    step();

    // Initial carry only on bit 0
    launch(8'h00, 8'h00, 1'b1);
    n_cin = 0;
    check("cin_first_bit", alu_c_in, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) step();
      if (alu_c_in === 1'b1) n_cin++;
    end
    check("cin_once", n_cin, 1);
    step();
    check("cin_done", done, 1'b1);
    check("cin_result", result, 8'h01);
    check("cin_c_out", c_out, 1'b0);
    step();

    // Starts during SHIFT (cycle 3) and DONE (cycle 9) are ignored
    launch(8'h12, 8'h34, 1'b0);
    n_done = 0;
    for (int k = 2; k <= 9; k++) begin
      step();
      if (done === 1'b1) n_done++;
      if (k == 3 || k == 9) begin
        a     = 8'hFF;
        b     = 8'hFF;
        c_in  = 1'b1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check("ign_result", result, 8'h46);
    check("ign_c_out", c_out, 1'b0);
    step();
    start = 1'b0;
    check("ign_not_queued", busy, 1'b0);
    check("ign_hold_result", result, 8'h46);
    for (int k = 0; k < 4; k++) begin
      step();
      if (done === 1'b1) n_done++;
    end
    check("ign_single_done", n_done, 1);
    check("ign_still_idle", dbg_state, ST_IDLE);

    // Reset after 4 bits abandons the operation
    launch(8'hFF, 8'hFF, 1'b1);
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_result", result, 8'h00);
    check("midrst_state", dbg_state, ST_IDLE);
    check("midrst_done", done, 1'b0);
    step();
    rst = 1'b0;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done === 1'b1) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    launch(8'h01, 8'h01, 1'b0);
    wait_done(lat);
    check("midrst_next_result", result, 8'h02);
    check("midrst_next_c_out", c_out, 1'b0);
    step();

    // start held high: one accept every 10 cycles
    vec_a[0] = 8'h5A; vec_b[0] = 8'h3C; vec_res[0] = 8'h96; vec_co[0] = 1'b0;
    vec_a[1] = 8'h80; vec_b[1] = 8'h80; vec_res[1] = 8'h00; vec_co[1] = 1'b1;
    vec_a[2] = 8'h0F; vec_b[2] = 8'h01; vec_res[2] = 8'h10; vec_co[2] = 1'b0;
    vec_a[3] = 8'h00; vec_b[3] = 8'h00;
    a     = vec_a[0];
    b     = vec_b[0];
    c_in  = 1'b0;
    oper  = OPER_ADD;
    start = 1'b1;
    step();
    for (int c = 1; c < 30; c++) begin
      if (c > 1) step();
      if (c % 10 == 1) begin
        a = vec_a[c / 10 + 1];
        b = vec_b[c / 10 + 1];
      end
      check("b2b_busy", busy, ((c % 10) != 0));
      check("b2b_done", done, ((c % 10) == 9));
      if (c % 10 == 9) begin
        check("b2b_result", result, vec_res[c / 10]);
        check("b2b_c_out", c_out, vec_co[c / 10]);
      end
    end
    start = 1'b0;
    step();
    check("b2b_end_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
